// File: rtl/ram_hs_sync.sv
//------------------------------------------------------------------------------
// Module      : ram_hs_sync
// Description : Clocked byte-addressable big-endian RAM with an Enable/MFC
//               handshake. Supports byte/half/word/dword accesses with
//               wrap-around addressing and a configurable response delay.
//               Optional macro RAM_HS_RAND_WAIT_EN adds 0..3 pseudo-random
//               extra wait cycles per transaction, drawn from an 8-bit LFSR.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_hs_sync #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2     // legal range 0..15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              ReadWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [1:0]        DataSize,
    input  logic [63:0]       DataIn,
    output logic [63:0]       DataOut,
    output logic              MFC
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Counter is 5 bits so WAIT_STATES (max 15) plus the random extra (max 3) fits.
    logic [4:0]        r_cnt;
    logic [4:0]        w_cnt_nxt;
    logic [4:0]        w_cnt_load;

    logic              r_mfc;
    logic              w_mfc_nxt;
    logic [63:0]       r_dout;
    logic [63:0]       w_dout_nxt;

    logic              w_capture;
    logic              w_access;

    // Request fields frozen at capture; later input changes are ignored.
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_rw;
    logic [63:0]       r_din;

    logic [7:0]        r_mem [c_DEPTH];

    logic [7:0]        w_lane_mask;
    logic [5:0]        w_shamt;
    logic [63:0]       w_din_lj;
    logic [63:0]       w_rd_lj;
    logic [63:0]       w_rdata;
    logic [ADDR_W-1:0] w_baddr [8];
    logic [7:0]        w_wbyte [8];
    logic [7:0]        w_wen;

`ifdef RAM_HS_RAND_WAIT_EN
    logic [7:0]        r_lfsr;

    // Free-running Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reseeded by Reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_cnt_load = 5'(WAIT_STATES) + {3'b000, r_lfsr[1:0]};
`else
    assign w_cnt_load = 5'(WAIT_STATES);
`endif

    // Lane mask (bit n = access byte n, n=0 most significant) and the shift
    // that moves right-aligned data to/from a left-justified 64-bit lane view.
    always_comb begin
        w_lane_mask = 8'h01;
        w_shamt     = 6'd56;
        case (r_size)
            2'b00: begin w_lane_mask = 8'h01; w_shamt = 6'd56; end
            2'b01: begin w_lane_mask = 8'h03; w_shamt = 6'd48; end
            2'b10: begin w_lane_mask = 8'h0F; w_shamt = 6'd32; end
            default: begin w_lane_mask = 8'hFF; w_shamt = 6'd0; end
        endcase
    end

    assign w_din_lj = r_din << w_shamt;

    // Per-lane byte addresses (modulo depth) and read/write byte steering.
    always_comb begin
        w_rd_lj = '0;
        w_wen   = '0;
        for (int n = 0; n < 8; n++) begin
            w_baddr[n] = r_addr + ADDR_W'(n);
            w_wbyte[n] = w_din_lj[63-8*n -: 8];
            if (w_lane_mask[n]) begin
                w_rd_lj[63-8*n -: 8] = r_mem[w_baddr[n]];
            end
            // Reset on the access edge discards the pending write.
            w_wen[n] = w_access && !r_rw && w_lane_mask[n] && !Reset;
        end
    end

    assign w_rdata = w_rd_lj >> w_shamt;

    // Storage array; deliberately not cleared by Reset.
    always_ff @(posedge Clk) begin
        for (int n = 0; n < 8; n++) begin
            if (w_wen[n]) begin
                r_mem[w_baddr[n]] <= w_wbyte[n];
            end
        end
    end

    // Handshake next-state and output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mfc_nxt   = r_mfc;
        w_dout_nxt  = r_dout;
        w_capture   = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            IDLE: begin
                w_mfc_nxt = 1'b0;
                if (Enable) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = w_cnt_load;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!Enable) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt != 5'd0) begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end else begin
                    w_access    = 1'b1;
                    w_mfc_nxt   = 1'b1;
                    w_state_nxt = ACK;
                    if (r_rw) begin
                        w_dout_nxt = w_rdata;
                    end
                end
            end
            ACK: begin
                // Requester must drop Enable before another capture is possible.
                if (!Enable) begin
                    w_mfc_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_mfc_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= 5'd0;
            r_mfc   <= 1'b0;
            r_dout  <= 64'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mfc   <= w_mfc_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

    // Request capture registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_addr <= '0;
            r_size <= 2'b00;
            r_rw   <= 1'b0;
            r_din  <= 64'd0;
        end else if (w_capture) begin
            r_addr <= Address;
            r_size <= DataSize;
            r_rw   <= ReadWrite;
            r_din  <= DataIn;
        end
    end

    assign MFC     = r_mfc;
    assign DataOut = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_ram_hs_sync.sv
//------------------------------------------------------------------------------
// Module      : tb_ram_hs_sync
// Description : Self-checking bench for ram_hs_sync against a byte-array
//               reference model. Honours RAM_HS_RAND_WAIT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_hs_sync;

    localparam int c_WS = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic        ReadWrite = 1'b0;
    logic [7:0]  Address = 8'h00;
    logic [1:0]  DataSize = 2'b00;
    logic [63:0] DataIn = 64'd0;
    logic [63:0] DataOut;
    logic        MFC;

    int          vectors = 0;
    int          miscompares = 0;
    int          lat_hist [4];
    logic [7:0]  model [256];

    ram_hs_sync #(.ADDR_W(8), .WAIT_STATES(c_WS)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Enable   (Enable),
        .ReadWrite(ReadWrite),
        .Address  (Address),
        .DataSize (DataSize),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .MFC      (MFC)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_read(input logic [7:0] a, input logic [1:0] sz);
        logic [63:0] r = 64'd0;
        int nb = 1 << sz;
        for (int n = 0; n < nb; n++) r = (r << 8) | 64'(model[8'(a + n)]);
        return r;
    endfunction

    function automatic void ref_write(input logic [7:0] a, input logic [1:0] sz, input logic [63:0] d);
        int nb = 1 << sz;
        for (int n = 0; n < nb; n++) model[8'(a + n)] = 8'(d >> (8 * (nb - 1 - n)));
    endfunction

    // One handshake: issue, wait for MFC (bounded), hold Enable 'hold' extra
    // cycles, drop Enable and confirm MFC falls on the next edge.
    task automatic txn(input logic rw, input logic [7:0] a, input logic [1:0] sz,
                       input logic [63:0] d, input int hold, output logic [63:0] q);
        int lat;
        @(negedge Clk);
        Enable = 1'b1; ReadWrite = rw; Address = a; DataSize = sz; DataIn = d;
        @(posedge Clk);
        #1;
        // Scramble request inputs after capture; the DUT must ignore them.
        ReadWrite = $urandom_range(0, 1); Address = 8'($urandom);
        DataSize = 2'($urandom); DataIn = {$urandom, $urandom};
        lat = 0;
        do begin
            @(posedge Clk); #1; lat++;
        end while (!MFC && lat < 40);
        q = DataOut;
`ifdef RAM_HS_RAND_WAIT_EN
        chk("latency_range", 64'(lat >= c_WS + 1 && lat <= c_WS + 4), 64'd1);
        if (lat >= c_WS + 1 && lat <= c_WS + 4) lat_hist[lat - c_WS - 1]++;
`else
        chk("latency", 64'(lat), 64'(c_WS + 1));
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge Clk); #1;
            chk("mfc_held", 64'(MFC), 64'd1);
            chk("dout_held", DataOut, q);
        end
        @(negedge Clk);
        Enable = 1'b0;
        @(posedge Clk); #1;
        chk("mfc_fall", 64'(MFC), 64'd0);
        if (rw) chk("read_data", q, ref_read(a, sz));
        else ref_write(a, sz, d);
    endtask

    initial begin
        logic [63:0] q;
        logic [63:0] prev_dout;
        logic        rw;
        logic [7:0]  a;
        logic [1:0]  sz;
        logic [63:0] d;

        for (int i = 0; i < 4; i++) lat_hist[i] = 0;

        // Reset for two cycles.
        repeat (2) @(posedge Clk);
        @(negedge Clk); Reset = 1'b0;
        #1;
        chk("reset_mfc", 64'(MFC), 64'd0);
        chk("reset_dout", DataOut, 64'd0);

        // Program-load every byte with random dwords.
        for (int i = 0; i < 32; i++) txn(1'b0, 8'(i * 8), 2'b11, {$urandom, $urandom}, 0, q);

        // A read, then reset: outputs clear, memory contents survive.
        txn(1'b1, 8'h40, 2'b11, 64'd0, 0, q);
        @(negedge Clk); Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset2_mfc", 64'(MFC), 64'd0);
        chk("reset2_dout", DataOut, 64'd0);
        @(negedge Clk); Reset = 1'b0;
        for (int i = 0; i < 4; i++) txn(1'b1, 8'(i * 64 + 3), 2'b11, 64'd0, 0, q);

        // Big-endian word write, byte read-back.
        txn(1'b0, 8'h10, 2'b10, 64'h1111_2222_DEAD_BEEF, 0, q);
        txn(1'b1, 8'h10, 2'b00, 64'd0, 0, q); chk("be_b0", q, 64'hDE);
        txn(1'b1, 8'h11, 2'b00, 64'd0, 0, q); chk("be_b1", q, 64'hAD);
        txn(1'b1, 8'h12, 2'b00, 64'd0, 0, q); chk("be_b2", q, 64'hBE);
        txn(1'b1, 8'h13, 2'b00, 64'd0, 0, q); chk("be_b3", q, 64'hEF);

        // Dword across the top of the address space.
        txn(1'b0, 8'hFC, 2'b11, 64'h0123_4567_89AB_CDEF, 0, q);
        txn(1'b1, 8'hFE, 2'b01, 64'd0, 0, q); chk("wrap_half", q, 64'h4567);
        txn(1'b1, 8'h00, 2'b00, 64'd0, 0, q); chk("wrap_byte", q, 64'h89);

        // Enable held through ACK: MFC stays up, no second transaction.
        txn(1'b1, 8'h10, 2'b10, 64'd0, 5, q); chk("hold_word", q, 64'hDEAD_BEEF);

        // Known value at 0x20, then a write aborted by dropping Enable in WAIT.
        txn(1'b0, 8'h20, 2'b00, 64'h11, 0, q);
        @(negedge Clk);
        Enable = 1'b1; ReadWrite = 1'b0; Address = 8'h20; DataSize = 2'b00; DataIn = 64'h55;
        @(posedge Clk);
        @(negedge Clk); Enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            chk("abort_mfc", 64'(MFC), 64'd0);
        end
        txn(1'b1, 8'h20, 2'b00, 64'd0, 0, q); chk("abort_old", q, 64'h11);

        // Reset during WAIT of a write: aborted, outputs cleared.
        txn(1'b1, 8'h10, 2'b10, 64'd0, 0, q);
        prev_dout = q;
        chk("pre_reset_dout", prev_dout, 64'hDEAD_BEEF);
        @(negedge Clk);
        Enable = 1'b1; ReadWrite = 1'b0; Address = 8'h20; DataSize = 2'b00; DataIn = 64'h77;
        @(posedge Clk);
        @(negedge Clk); Reset = 1'b1;
        @(posedge Clk); #1;
        chk("rst_wait_mfc", 64'(MFC), 64'd0);
        chk("rst_wait_dout", DataOut, 64'd0);
        @(negedge Clk); Reset = 1'b0; Enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            chk("rst_wait_idle", 64'(MFC), 64'd0);
        end
        txn(1'b1, 8'h20, 2'b00, 64'd0, 0, q); chk("rst_wait_old", q, 64'h11);

        // Randomised traffic against the model.
        for (int i = 0; i < 60; i++) begin
            rw = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            sz = 2'($urandom);
            d  = {$urandom, $urandom};
            txn(rw, a, sz, d, $urandom_range(0, 2), q);
        end

`ifdef RAM_HS_RAND_WAIT_EN
        for (int i = 0; i < 4; i++) lat_hist[i] = 0;
        for (int i = 0; i < 50; i++) txn(1'b1, 8'($urandom), 2'($urandom), 64'd0, 0, q);
        for (int i = 0; i < 4; i++) chk("latency_seen", 64'(lat_hist[i] > 0), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_hs_sync.md
Name: ram_hs_sync

Overview:
- Clocked, parametrised successor to the 256-byte asynchronous handshake RAM used by the processor.
- Byte-addressable, big-endian storage; supports byte, halfword, word and doubleword (64-bit) access.
- Uses the Enable/MFC handshake with a programmable response delay, so the CPU control unit cannot rely on fixed memory timing.
- Sits between the CPU memory interface (MAR/MDR path) and the testbench program loader.

Parameters:
- ADDR_W, 8: address width; depth = 2**ADDR_W bytes (default 256).
- WAIT_STATES, 2: fixed extra cycles between request capture and access; range 0..15.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Enable  input  1  request strobe; held high by the requester until MFC is seen.
- ReadWrite  input  1  1 = read, 0 = write.
- Address  input  ADDR_W  byte address of the most-significant byte.
- DataSize  input  2  00 byte, 01 half, 10 word, 11 dword.
- DataIn  input  64  write data, right-aligned.
- DataOut  output  64  read data, right-aligned, upper bits zero.
- MFC  output  1  memory function complete.

Behaviour:
- Clock and reset are fixed: one clock, Clk; Reset is synchronous and active-high.
- Reset: state IDLE, MFC=0, DataOut=0, counter=0. The memory array is not cleared.
- Reset mid-transaction: the transaction is aborted and any pending write is discarded.
- States: IDLE, WAIT, ACK.
- IDLE:
  - On a rising edge with Enable=1, latch Address, DataSize, ReadWrite and DataIn.
  - Load the counter with WAIT_STATES; go to WAIT.
- WAIT:
  - If Enable=0, abort: go to IDLE, no memory update, MFC stays 0.
  - Else if counter!=0, decrement.
  - Else perform the access, set MFC=1, go to ACK.
- ACK:
  - MFC held at 1 and DataOut held.
  - When Enable=0, clear MFC and go to IDLE (MFC falls one edge after Enable falls).
- Latency: request captured at edge k -> MFC high after edge k+WAIT_STATES+1. With WAIT_STATES=0 this is one cycle.
- Enable held high through ACK does not start a new transaction. Enable must be seen low before the next request.
- Input changes after capture are ignored until the next IDLE capture.
- Big-endian layout:
  - Byte n of the access, n=0 being most significant, lives at Address+n.
  - Widths: half uses DataIn/DataOut[15:0], word [31:0], dword [63:0]. Byte at Address maps to the top bit-lane of that width.
- Reads write the full 64-bit DataOut, with unused upper bits set to 0. Writes modify only the addressed bytes. DataOut is unchanged by writes.
- Address arithmetic is modulo 2**ADDR_W: an access crossing the top wraps to address 0. No alignment requirement, no fault.
- MFC is a registered output. DataOut is valid in the same cycle MFC first reads 1.

Optional Feature:
- Macro: RAM_HS_RAND_WAIT_EN.
- When defined:
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, reset seed 8'hA5) advances every clock.
  - At capture, counter = WAIT_STATES + lfsr[1:0], giving latency in the range WAIT_STATES+1..WAIT_STATES+4.
  - The LFSR reset value is restored by Reset.
- When undefined: latency is exactly WAIT_STATES+1 and no LFSR logic exists.

Test Plan:
- Reset high 2 cycles, then low -> MFC=0, DataOut=64'h0; memory read of any address returns the pre-loaded contents unchanged.
- Write word 32'hDEADBEEF at 8'h10 (WAIT_STATES=2), drop Enable after MFC; byte reads of 10..13 -> 64'hDE, 64'hAD, 64'hBE, 64'hEF. MFC rises exactly 3 cycles after capture.
- Write dword 64'h0123456789ABCDEF at 8'hFC; half read at 8'hFE -> 64'h4567; byte read at 8'h00 -> 64'h89 (wrap-around).
- Read word at 8'h10 and keep Enable high 5 cycles after MFC -> MFC stays 1, no second transaction. Drop Enable -> MFC=0 next edge.
- Write byte 8'h55 at 8'h20, drop Enable during WAIT -> MFC never asserts; a later byte read of 8'h20 returns the old value. Assert Reset during WAIT of another write -> same, with MFC=0 and DataOut=0.
- With RAM_HS_RAND_WAIT_EN, run 50 back-to-back reads -> every latency lies in WAIT_STATES+1..WAIT_STATES+4, and all four values occur.
